// File: rtl/fetch_unit_if.sv
// Handshake/bus bundle for fetch_unit: imem port, redirect, stall and queue-head outputs.
// Statistics counters are present only when FETCH_STATS_EN is defined.
interface fetch_unit_if;
    logic        start_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] redirect_cnt_o;
`endif

    modport master (
        input  start_i, imem_instr_i, redirect_i, redirect_pc_i, stall_i,
`ifdef FETCH_STATS_EN
        output fetch_cnt_o, redirect_cnt_o,
`endif
        output imem_addr_o, valid_o, pc_o, instr_o
    );

    modport slave (
        output start_i, imem_instr_i, redirect_i, redirect_pc_i, stall_i,
`ifdef FETCH_STATS_EN
        input  fetch_cnt_o, redirect_cnt_o,
`endif
        input  imem_addr_o, valid_o, pc_o, instr_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and buffers fetched words in a QDEPTH-entry queue.
// Define FETCH_STATS_EN to add push/redirect counters.
module fetch_unit #(
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);
    localparam int          PW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] FULL_OCC = (PW + 1)'(QDEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   occ;
    logic          head_valid;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    logic          pop;
    logic          push;
    logic [PW:0]   occ_after_pop;
    logic [PW:0]   occ_next;
    logic [PW-1:0] head_next;

    // A pop frees a slot this same cycle, so a full queue can still accept a push.
    always_comb begin
        pop           = (occ != '0) && !bus.stall_i && !bus.redirect_i;
        push          = (state == RUN) && ((occ != FULL_OCC) || pop) && !bus.redirect_i;
        occ_after_pop = occ - {{PW{1'b0}}, pop};
        occ_next      = occ_after_pop + {{PW{1'b0}}, push};
        head_next     = pop ? head + 1'b1 : head;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            occ        <= '0;
            head_valid <= 1'b0;
            head_pc    <= '0;
            head_instr <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (bus.start_i)  state <= RUN;
                RUN:  if (!bus.start_i) state <= IDLE;
            endcase

            if (bus.redirect_i) begin
                pc         <= {bus.redirect_pc_i[31:2], 2'b00};
                head       <= '0;
                tail       <= '0;
                occ        <= '0;
                head_valid <= 1'b0;
            end else begin
                if (push) begin
                    q_pc[tail]    <= pc;
                    q_instr[tail] <= bus.imem_instr_i;
                    tail          <= tail + 1'b1;
                    pc            <= pc + 32'd4;
                end
                occ        <= occ_next;
                head       <= head_next;
                head_valid <= (occ_next != '0);
                // The output register bypasses the queue when the new word lands at an empty head.
                if (push && (occ_after_pop == '0)) begin
                    head_pc    <= pc;
                    head_instr <= bus.imem_instr_i;
                end else if (pop) begin
                    head_pc    <= q_pc[head_next];
                    head_instr <= q_instr[head_next];
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (push)           fetch_cnt    <= fetch_cnt + 32'd1;
            if (bus.redirect_i) redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

    assign bus.fetch_cnt_o    = fetch_cnt;
    assign bus.redirect_cnt_o = redirect_cnt;
`endif

    assign bus.imem_addr_o = pc;
    assign bus.valid_o     = head_valid;
    assign bus.pc_o        = head_pc;
    assign bus.instr_o     = head_instr;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;
    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;
    fetch_unit_if bus ();

    fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    always_comb bus.imem_instr_i = imem_word(bus.imem_addr_o);

    // Reference model: an unbounded-looking queue capped at QDEPTH, a PC and a run flag.
    logic [31:0] model_q[$];
    logic [31:0] model_pc;
    logic        model_run;
    int unsigned model_fetches;
    int unsigned model_redirects;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic modelReset();
        model_q.delete();
        model_pc        = RESET_PC;
        model_run       = 1'b0;
        model_fetches   = 0;
        model_redirects = 0;
    endtask

    task automatic modelStep(input logic start, input logic redirect, input logic [31:0] rpc, input logic stall);
        int  occ;
        logic popping;
        occ     = model_q.size();
        popping = (occ != 0) && !stall;
        if (redirect) begin
            model_q.delete();
            model_pc = {rpc[31:2], 2'b00};
            model_redirects++;
        end else begin
            logic pushing;
            pushing = model_run && ((occ < QDEPTH) || popping);
            if (popping) void'(model_q.pop_front());
            if (pushing) begin
                model_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                model_fetches++;
            end
        end
        model_run = start;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".addr"}, bus.imem_addr_o, model_pc);
        checkOutput({tag, ".valid"}, {31'd0, bus.valid_o}, {31'd0, model_q.size() != 0});
        if (model_q.size() != 0) begin
            checkOutput({tag, ".pc"}, bus.pc_o, model_q[0]);
            checkOutput({tag, ".instr"}, bus.instr_o, imem_word(model_q[0]));
        end
`ifdef FETCH_STATS_EN
        checkOutput({tag, ".fcnt"}, bus.fetch_cnt_o, model_fetches);
        checkOutput({tag, ".rcnt"}, bus.redirect_cnt_o, model_redirects);
`endif
    endtask

    task automatic compareReset(input string tag);
        checkOutput({tag, ".addr"}, bus.imem_addr_o, RESET_PC);
        checkOutput({tag, ".valid"}, {31'd0, bus.valid_o}, 32'd0);
        checkOutput({tag, ".pc"}, bus.pc_o, 32'd0);
        checkOutput({tag, ".instr"}, bus.instr_o, 32'd0);
`ifdef FETCH_STATS_EN
        checkOutput({tag, ".fcnt"}, bus.fetch_cnt_o, 32'd0);
        checkOutput({tag, ".rcnt"}, bus.redirect_cnt_o, 32'd0);
`endif
    endtask

    // Drives one cycle of inputs, advances the model at the edge, then compares just after it.
    task automatic applyStimulus(input string tag, input logic start, input logic redirect,
                                 input logic [31:0] rpc, input logic stall);
        bus.start_i       = start;
        bus.redirect_i    = redirect;
        bus.redirect_pc_i = rpc;
        bus.stall_i       = stall;
        @(posedge clk);
        modelStep(start, redirect, rpc, stall);
        #1;
        compareAll(tag);
    endtask

    initial begin
        bus.start_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.stall_i       = 1'b0;
        rst = 1'b1;
        modelReset();
        #12;
        compareReset("reset");
        rst = 1'b0;

        for (int i = 0; i < 2; i++) applyStimulus("idle", 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus("start", 1'b1, 1'b0, '0, 1'b0);
        checkOutput("stream.pc", bus.pc_o, 32'd24);

        for (int i = 0; i < 6; i++) applyStimulus("stall", 1'b1, 1'b0, '0, 1'b1);
        checkOutput("stall.freeze", bus.imem_addr_o, bus.pc_o + 32'd8);
        for (int i = 0; i < 4; i++) applyStimulus("release", 1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 3; i++) applyStimulus("fill", 1'b1, 1'b0, '0, 1'b1);
        applyStimulus("redir", 1'b1, 1'b1, 32'h0000_0103, 1'b0);
        checkOutput("redir.target", bus.imem_addr_o, 32'h0000_0100);
        applyStimulus("redir1", 1'b1, 1'b0, '0, 1'b0);
        checkOutput("redir.head", bus.pc_o, 32'h0000_0100);
        for (int i = 0; i < 3; i++) applyStimulus("redir2", 1'b1, 1'b0, '0, 1'b0);

        applyStimulus("redirstall", 1'b1, 1'b1, 32'h0000_0400, 1'b1);
        applyStimulus("redirstall1", 1'b1, 1'b0, '0, 1'b1);
        applyStimulus("redirstall2", 1'b1, 1'b0, '0, 1'b0);

        applyStimulus("wrap", 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("wrap", 1'b1, 1'b0, '0, 1'b0);
        checkOutput("wrap.head", bus.pc_o, 32'h0000_0000);
        for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand", $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0,
                          $urandom, $urandom_range(0, 2) == 0);
        end

        for (int i = 0; i < 5; i++) applyStimulus("prereset", 1'b1, 1'b0, '0, 1'b1);
        #3 rst = 1'b1;
        #1;
        compareReset("asyncreset");
        modelReset();
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus("postreset", 1'b1, 1'b0, '0, 1'b0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
